age_ordered_rs: RTL and testbench

Parametrised reservation station for the Tomasulo backend: holds dispatched instructions until their A/B operands and NZCV flags are valid, then issues the oldest ready entry to one functional unit over a valid/ready handshake. It sits between the ROB (dispatch, result broadcast, mispredict) and a single FU (ALU or LS); the top level instantiates one per FU. It adds features the single-broadcast station lacks:

- multiple broadcast channels
- oldest-first issue by ROB age
- same-cycle broadcast capture on insert
- selective flush of entries younger than a mispredicted branch
- full/count backpressure to the ROB

---
 rtl/age_ordered_rs.sv | 194 +++++++++++++++++++
 tb/tb_age_ordered_rs.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station: buffers dispatched ops until operands/flags arrive,
// then issues the oldest ready entry (by ROB age) to one functional unit.
package age_ordered_rs_pkg;
    typedef logic [3:0] fu_op_t;
    typedef logic [3:0] cond_t;
    typedef logic [3:0] nzcv_t;
endpackage

module age_ordered_rs
    import age_ordered_rs_pkg::*;
#(
    parameter int RS_SIZE      = 8,
    parameter int ROB_IDX_SIZE = 4,
    parameter int DATA_W       = 64,
    parameter int NUM_BCAST    = 2
) (
    input  logic                            in_clk,
    input  logic                            in_rst,
    input  logic [ROB_IDX_SIZE-1:0]         in_rob_head_index,
    input  logic                            in_rob_done,
    output logic                            out_rs_full,
    output logic [$clog2(RS_SIZE+1)-1:0]    out_rs_count,
    input  fu_op_t                          in_rob_fu_op,
    input  cond_t                           in_rob_cond_codes,
    input  logic [ROB_IDX_SIZE-1:0]         in_rob_dst_rob_index,
    input  logic                            in_rob_val_a_valid,
    input  logic                            in_rob_val_b_valid,
    input  logic [DATA_W-1:0]               in_rob_val_a_value,
    input  logic [DATA_W-1:0]               in_rob_val_b_value,
    input  logic [ROB_IDX_SIZE-1:0]         in_rob_val_a_rob_index,
    input  logic [ROB_IDX_SIZE-1:0]         in_rob_val_b_rob_index,
    input  logic                            in_rob_uses_nzcv,
    input  logic                            in_rob_nzcv_valid,
    input  nzcv_t                           in_rob_nzcv,
    input  logic [ROB_IDX_SIZE-1:0]         in_rob_nzcv_rob_index,
    input  logic                            in_rob_set_nzcv,
    input  logic [NUM_BCAST-1:0]            in_rob_broadcast_done,
    input  logic [NUM_BCAST*ROB_IDX_SIZE-1:0] in_rob_broadcast_index,
    input  logic [NUM_BCAST*DATA_W-1:0]     in_rob_broadcast_value,
    input  logic [NUM_BCAST-1:0]            in_rob_broadcast_set_nzcv,
    input  logic [NUM_BCAST*4-1:0]          in_rob_broadcast_nzcv,
    input  logic                            in_rob_is_mispred,
    input  logic [ROB_IDX_SIZE-1:0]         in_rob_mispred_index,
    input  logic                            in_fu_ready,
    output logic                            out_fu_start,
    output fu_op_t                          out_fu_op,
    output logic [DATA_W-1:0]               out_fu_val_a,
    output logic [DATA_W-1:0]               out_fu_val_b,
    output logic [ROB_IDX_SIZE-1:0]         out_fu_dst_rob_index,
    output logic                            out_fu_set_nzcv,
    output nzcv_t                           out_fu_nzcv,
    output cond_t                           out_fu_cond_codes
);
    localparam int RI    = ROB_IDX_SIZE;
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = $clog2(RS_SIZE+1);

    typedef struct packed {
        logic              valid;
        fu_op_t            op;
        cond_t             cond;
        logic [RI-1:0]     dst;
        logic              a_valid;
        logic [DATA_W-1:0] a_value;
        logic [RI-1:0]     a_tag;
        logic              b_valid;
        logic [DATA_W-1:0] b_value;
        logic [RI-1:0]     b_tag;
        logic              uses_nzcv;
        logic              set_nzcv;
        logic              f_valid;
        nzcv_t             f_value;
        logic [RI-1:0]     f_tag;
    } entry_t;

    entry_t rs_q [RS_SIZE];
    entry_t rs_d [RS_SIZE];
    entry_t ins_entry;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [RI-1:0]    sel_age;
    logic [IDX_W-1:0] free_idx;
    logic [RI-1:0]    mis_age;

    function automatic logic [RI-1:0] age_of(input logic [RI-1:0] tag);
        return RI'(tag - in_rob_head_index);
    endfunction

    function automatic logic is_ready(input entry_t e);
        return e.valid && e.a_valid && e.b_valid && (e.f_valid || !e.uses_nzcv);
    endfunction

    // Channels are scanned high to low so the lowest matching channel is applied last and wins.
    function automatic entry_t wake(input entry_t e);
        entry_t r;
        r = e;
        for (int c = NUM_BCAST-1; c >= 0; c--) begin
            if (in_rob_broadcast_done[c] && e.valid) begin
                if (!e.a_valid && e.a_tag == in_rob_broadcast_index[c*RI +: RI]) begin
                    r.a_valid = 1'b1;
                    r.a_value = in_rob_broadcast_value[c*DATA_W +: DATA_W];
                end
                if (!e.b_valid && e.b_tag == in_rob_broadcast_index[c*RI +: RI]) begin
                    r.b_valid = 1'b1;
                    r.b_value = in_rob_broadcast_value[c*DATA_W +: DATA_W];
                end
                if (in_rob_broadcast_set_nzcv[c] && !e.f_valid &&
                    e.f_tag == in_rob_broadcast_index[c*RI +: RI]) begin
                    r.f_valid = 1'b1;
                    r.f_value = in_rob_broadcast_nzcv[c*4 +: 4];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        sel_found    = 1'b0;
        sel_idx      = '0;
        sel_age      = '0;
        free_idx     = '0;
        out_rs_full  = 1'b1;
        out_rs_count = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (is_ready(rs_q[i]) && (!sel_found || age_of(rs_q[i].dst) < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_of(rs_q[i].dst);
            end
            out_rs_count = out_rs_count + CNT_W'(rs_q[i].valid);
            out_rs_full  = out_rs_full & rs_q[i].valid;
        end
        for (int i = RS_SIZE-1; i >= 0; i--) begin
            if (!rs_q[i].valid) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        out_fu_start         = sel_found && !in_rob_is_mispred && !in_rst;
        out_fu_op            = '0;
        out_fu_val_a         = '0;
        out_fu_val_b         = '0;
        out_fu_dst_rob_index = '0;
        out_fu_set_nzcv      = 1'b0;
        out_fu_nzcv          = '0;
        out_fu_cond_codes    = '0;
        if (sel_found) begin
            out_fu_op            = rs_q[sel_idx].op;
            out_fu_val_a         = rs_q[sel_idx].a_value;
            out_fu_val_b         = rs_q[sel_idx].b_value;
            out_fu_dst_rob_index = rs_q[sel_idx].dst;
            out_fu_set_nzcv      = rs_q[sel_idx].set_nzcv;
            out_fu_nzcv          = rs_q[sel_idx].f_value;
            out_fu_cond_codes    = rs_q[sel_idx].cond;
        end
    end

    always_comb begin
        ins_entry           = '0;
        ins_entry.valid     = 1'b1;
        ins_entry.op        = in_rob_fu_op;
        ins_entry.cond      = in_rob_cond_codes;
        ins_entry.dst       = in_rob_dst_rob_index;
        ins_entry.a_valid   = in_rob_val_a_valid;
        ins_entry.a_value   = in_rob_val_a_value;
        ins_entry.a_tag     = in_rob_val_a_rob_index;
        ins_entry.b_valid   = in_rob_val_b_valid;
        ins_entry.b_value   = in_rob_val_b_value;
        ins_entry.b_tag     = in_rob_val_b_rob_index;
        ins_entry.uses_nzcv = in_rob_uses_nzcv;
        ins_entry.set_nzcv  = in_rob_set_nzcv;
        ins_entry.f_valid   = in_rob_nzcv_valid;
        ins_entry.f_value   = in_rob_nzcv;
        ins_entry.f_tag     = in_rob_nzcv_rob_index;

        mis_age = age_of(in_rob_mispred_index);
        for (int i = 0; i < RS_SIZE; i++) begin
            rs_d[i] = wake(rs_q[i]);
            if (in_rob_is_mispred && age_of(rs_q[i].dst) > mis_age) rs_d[i].valid = 1'b0;
        end
        // Issue and insert never collide: the issued slot is occupied, the insert slot is free.
        if (out_fu_start && in_fu_ready) rs_d[sel_idx].valid = 1'b0;
        if (in_rob_done && !out_rs_full && !in_rob_is_mispred) rs_d[free_idx] = wake(ins_entry);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < RS_SIZE; i++) rs_q[i] <= '0;
        end else begin
            rs_q <= rs_d;
        end
    end
endmodule

// File: tb/tb_age_ordered_rs.sv
// Directed bench for age_ordered_rs: ordering, wakeup, bypass, flush, backpressure, flags.
module tb_age_ordered_rs;
    logic        in_clk = 1'b0;
    logic        in_rst;
    logic [3:0]  in_rob_head_index;
    logic        in_rob_done;
    logic        out_rs_full;
    logic [3:0]  out_rs_count;
    logic [3:0]  in_rob_fu_op, in_rob_cond_codes, in_rob_dst_rob_index;
    logic        in_rob_val_a_valid, in_rob_val_b_valid;
    logic [63:0] in_rob_val_a_value, in_rob_val_b_value;
    logic [3:0]  in_rob_val_a_rob_index, in_rob_val_b_rob_index;
    logic        in_rob_uses_nzcv, in_rob_nzcv_valid, in_rob_set_nzcv;
    logic [3:0]  in_rob_nzcv, in_rob_nzcv_rob_index;
    logic [1:0]  in_rob_broadcast_done, in_rob_broadcast_set_nzcv;
    logic [7:0]  in_rob_broadcast_index, in_rob_broadcast_nzcv;
    logic [127:0] in_rob_broadcast_value;
    logic        in_rob_is_mispred;
    logic [3:0]  in_rob_mispred_index;
    logic        in_fu_ready;
    logic        out_fu_start, out_fu_set_nzcv;
    logic [3:0]  out_fu_op, out_fu_dst_rob_index, out_fu_nzcv, out_fu_cond_codes;
    logic [63:0] out_fu_val_a, out_fu_val_b;

    int total = 0;
    int bad   = 0;

    age_ordered_rs dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_rob_head_index(in_rob_head_index),
        .in_rob_done(in_rob_done), .out_rs_full(out_rs_full), .out_rs_count(out_rs_count),
        .in_rob_fu_op(in_rob_fu_op), .in_rob_cond_codes(in_rob_cond_codes),
        .in_rob_dst_rob_index(in_rob_dst_rob_index),
        .in_rob_val_a_valid(in_rob_val_a_valid), .in_rob_val_b_valid(in_rob_val_b_valid),
        .in_rob_val_a_value(in_rob_val_a_value), .in_rob_val_b_value(in_rob_val_b_value),
        .in_rob_val_a_rob_index(in_rob_val_a_rob_index),
        .in_rob_val_b_rob_index(in_rob_val_b_rob_index),
        .in_rob_uses_nzcv(in_rob_uses_nzcv), .in_rob_nzcv_valid(in_rob_nzcv_valid),
        .in_rob_nzcv(in_rob_nzcv), .in_rob_nzcv_rob_index(in_rob_nzcv_rob_index),
        .in_rob_set_nzcv(in_rob_set_nzcv),
        .in_rob_broadcast_done(in_rob_broadcast_done),
        .in_rob_broadcast_index(in_rob_broadcast_index),
        .in_rob_broadcast_value(in_rob_broadcast_value),
        .in_rob_broadcast_set_nzcv(in_rob_broadcast_set_nzcv),
        .in_rob_broadcast_nzcv(in_rob_broadcast_nzcv),
        .in_rob_is_mispred(in_rob_is_mispred), .in_rob_mispred_index(in_rob_mispred_index),
        .in_fu_ready(in_fu_ready), .out_fu_start(out_fu_start), .out_fu_op(out_fu_op),
        .out_fu_val_a(out_fu_val_a), .out_fu_val_b(out_fu_val_b),
        .out_fu_dst_rob_index(out_fu_dst_rob_index), .out_fu_set_nzcv(out_fu_set_nzcv),
        .out_fu_nzcv(out_fu_nzcv), .out_fu_cond_codes(out_fu_cond_codes)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are then changed 1 time unit after it.
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        in_rob_done = 0; in_rob_fu_op = 0; in_rob_cond_codes = 0; in_rob_dst_rob_index = 0;
        in_rob_val_a_valid = 0; in_rob_val_b_valid = 0;
        in_rob_val_a_value = 0; in_rob_val_b_value = 0;
        in_rob_val_a_rob_index = 0; in_rob_val_b_rob_index = 0;
        in_rob_uses_nzcv = 0; in_rob_nzcv_valid = 0; in_rob_set_nzcv = 0;
        in_rob_nzcv = 0; in_rob_nzcv_rob_index = 0;
        in_rob_broadcast_done = 0; in_rob_broadcast_set_nzcv = 0;
        in_rob_broadcast_index = 0; in_rob_broadcast_nzcv = 0; in_rob_broadcast_value = 0;
        in_rob_is_mispred = 0; in_rob_mispred_index = 0;
    endtask

    task automatic dispatch(input logic [3:0] dst, input logic av, input logic [63:0] aval,
                            input logic [3:0] atag, input logic bv, input logic [63:0] bval,
                            input logic [3:0] btag);
        in_rob_done = 1; in_rob_dst_rob_index = dst; in_rob_fu_op = dst; in_rob_cond_codes = ~dst;
        in_rob_val_a_valid = av; in_rob_val_a_value = aval; in_rob_val_a_rob_index = atag;
        in_rob_val_b_valid = bv; in_rob_val_b_value = bval; in_rob_val_b_rob_index = btag;
    endtask

    task automatic bcast(input int ch, input logic [3:0] idx, input logic [63:0] val,
                         input logic sn, input logic [3:0] f);
        in_rob_broadcast_done[ch] = 1'b1;
        in_rob_broadcast_index[ch*4 +: 4] = idx;
        in_rob_broadcast_value[ch*64 +: 64] = val;
        in_rob_broadcast_set_nzcv[ch] = sn;
        in_rob_broadcast_nzcv[ch*4 +: 4] = f;
    endtask

    initial begin
        idle();
        in_rst = 1; in_rob_head_index = 0; in_fu_ready = 0;
        step(); step();
        check("rst_start", out_fu_start, 0);
        check("rst_full", out_rs_full, 0);
        check("rst_count", out_rs_count, 0);
        check("rst_val_a", out_fu_val_a, 0);
        in_rst = 0;

        // Oldest-first across ROB index wrap: head 14, dsts 1,15,14 issue as 14,15,1.
        in_rob_head_index = 14;
        dispatch(1, 1, 64'h101, 0, 1, 0, 0); step();
        dispatch(15, 1, 64'h10f, 0, 1, 0, 0); step();
        dispatch(14, 1, 64'h10e, 0, 1, 0, 0); step();
        idle(); settle();
        check("wrap_count", out_rs_count, 3);
        check("wrap_dst0", out_fu_dst_rob_index, 14);
        in_fu_ready = 1; settle();
        check("wrap_val0", out_fu_val_a, 64'h10e);
        check("wrap_cc0", out_fu_cond_codes, 4'h1);
        step();
        check("wrap_dst1", out_fu_dst_rob_index, 15);
        step();
        check("wrap_dst2", out_fu_dst_rob_index, 1);
        check("wrap_op2", out_fu_op, 1);
        step();
        check("wrap_empty", out_fu_start, 0);
        check("wrap_cnt0", out_rs_count, 0);

        // Two channels wake both operands in one cycle.
        in_rob_head_index = 0; in_fu_ready = 0;
        dispatch(2, 0, 0, 3, 0, 0, 5); step();
        idle(); settle();
        check("dual_notready", out_fu_start, 0);
        bcast(0, 3, 64'h10, 0, 0); bcast(1, 5, 64'h20, 0, 0); settle();
        check("dual_no_same_cycle", out_fu_start, 0);
        step(); idle(); settle();
        check("dual_start", out_fu_start, 1);
        check("dual_a", out_fu_val_a, 64'h10);
        check("dual_b", out_fu_val_b, 64'h20);
        in_fu_ready = 1; step();
        check("dual_drained", out_rs_count, 0);

        // Insert bypass; channel 0 beats channel 1 on the same tag.
        in_fu_ready = 0;
        dispatch(3, 0, 0, 7, 1, 64'h5, 0);
        bcast(0, 7, 64'd42, 0, 0); bcast(1, 7, 64'd99, 0, 0);
        step(); idle(); settle();
        check("byp_start", out_fu_start, 1);
        check("byp_a", out_fu_val_a, 64'd42);
        in_fu_ready = 1; step();
        check("byp_drained", out_rs_count, 0);

        // Selective flush: 2,4,6 waiting on tag 8; mispredict at 4 with insert and wakeup.
        in_fu_ready = 0;
        dispatch(2, 0, 0, 8, 1, 0, 0); step();
        dispatch(4, 0, 0, 8, 1, 0, 0); step();
        dispatch(6, 0, 0, 8, 1, 0, 0); step();
        dispatch(7, 1, 0, 0, 1, 0, 0);
        in_rob_is_mispred = 1; in_rob_mispred_index = 4;
        bcast(0, 8, 64'h55, 0, 0);
        step(); idle(); settle();
        check("flush_count", out_rs_count, 2);
        check("flush_oldest", out_fu_dst_rob_index, 2);
        check("flush_wake", out_fu_val_a, 64'h55);
        in_rob_is_mispred = 1; in_rob_mispred_index = 4; in_fu_ready = 1; settle();
        check("flush_no_issue", out_fu_start, 0);
        step(); idle(); settle();
        check("flush_keep", out_rs_count, 2);
        step();
        check("flush_next", out_fu_dst_rob_index, 4);
        step();
        check("flush_drained", out_rs_count, 0);

        // Full and backpressure.
        in_fu_ready = 0;
        for (int i = 0; i < 8; i++) begin
            dispatch(4'(i), 1, 64'(i), 0, 1, 0, 0); step();
        end
        idle(); settle();
        check("full_flag", out_rs_full, 1);
        check("full_count", out_rs_count, 8);
        in_fu_ready = 1; dispatch(8, 1, 64'h8, 0, 1, 0, 0); settle();
        check("full_issue_dst", out_fu_dst_rob_index, 0);
        step();
        check("full_ignored", out_rs_count, 7);
        check("full_clear", out_rs_full, 0);
        in_fu_ready = 0; step(); idle(); settle();
        check("full_refill", out_rs_count, 8);
        in_fu_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_dst%0d", i), out_fu_dst_rob_index, 64'(i));
            step();
        end
        check("drain_empty", out_rs_count, 0);

        // Flag gating: only a flag-carrying broadcast on tag 9 makes the entry ready.
        in_fu_ready = 1;
        dispatch(10, 1, 0, 0, 1, 0, 0);
        in_rob_uses_nzcv = 1; in_rob_nzcv_valid = 0; in_rob_nzcv_rob_index = 9;
        step(); idle(); settle();
        check("nzcv_wait", out_fu_start, 0);
        bcast(0, 9, 64'h1, 0, 4'b1111); step(); idle(); settle();
        check("nzcv_no_flag_bcast", out_fu_start, 0);
        bcast(1, 9, 64'h2, 1, 4'b0100); step(); idle(); settle();
        check("nzcv_start", out_fu_start, 1);
        check("nzcv_value", out_fu_nzcv, 4'b0100);
        step();
        check("nzcv_drained", out_rs_count, 0);

        // Reset mid-operation discards a ready entry without issuing it.
        in_fu_ready = 1;
        dispatch(5, 1, 0, 0, 1, 0, 0); step(); idle();
        in_rst = 1; settle();
        check("rst_mid_no_issue", out_fu_start, 0);
        step(); in_rst = 0; settle();
        check("rst_mid_count", out_rs_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
